sorter_stack: RTL and testbench
===============================

SORTER_STACK -- requirements
Module: sorter_stack

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, giving the width of each data word in bits.
REQ-002 The module SHALL have parameter MAX_LENGTH, default 30, giving the maximum number of words stored per packet.
REQ-003 Port clock, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port snk_valid, input, 1 bit: sink word valid.
REQ-006 Port snk_sop, input, 1 bit: first word of the input packet.
REQ-007 Port snk_eop, input, 1 bit: last word of the input packet.
REQ-008 Port snk_data, input, DATA_WIDTH bits: input word, unsigned.
REQ-009 Port snk_ready, output, 1 bit: sink can accept a word.
REQ-010 Port src_valid, output, 1 bit: output word valid.
REQ-011 Port src_sop, output, 1 bit: first output word.
REQ-012 Port src_eop, output, 1 bit: last output word.
REQ-013 Port src_data, output, DATA_WIDTH bits: sorted output word.

Function
REQ-014 A word SHALL be accepted on a rising edge where snk_valid and snk_ready are both high.
REQ-015 The FSM SHALL have three states: IDLE, LOAD and OUTPUT.
REQ-016 snk_ready SHALL be high in IDLE and LOAD, and low in OUTPUT and during reset.
REQ-017 In IDLE, an accepted word with snk_sop high SHALL clear the store, insert the word, set count to 1 and move to LOAD; accepted words without snk_sop SHALL be ignored.
REQ-018 In LOAD, each accepted word SHALL be inserted in one cycle into a store kept in ascending unsigned order, using a parallel compare and shift-up.
REQ-019 Equal keys SHALL be placed after the existing equal entries, so the sort is stable.
REQ-020 If count equals MAX_LENGTH, further words SHALL be dropped, without any error output, until snk_eop arrives.
REQ-021 An accepted word with snk_sop high while in LOAD SHALL restart the packet: count becomes 1, holding that word.
REQ-022 An accepted word with snk_eop high SHALL be inserted (if there is room) and the FSM SHALL then move to OUTPUT.
REQ-023 A word carrying both snk_sop and snk_eop SHALL form a one-word packet.
REQ-024 In OUTPUT, store entries 0 to count-1 SHALL be driven, registered, one per cycle in ascending order, on consecutive cycles, with no backpressure.
REQ-025 The first output word SHALL be registered on the rising edge following the edge that accepted the eop word.
REQ-026 src_sop SHALL be high with the first output word and src_eop SHALL be high with the last; both SHALL be high for a one-word packet.
REQ-027 After the last output word, src_valid, src_sop and src_eop SHALL return low on the next edge and the FSM SHALL return to IDLE.
REQ-028 src_data SHALL hold its last value when src_valid is low.
REQ-029 Comparisons SHALL be unsigned and DATA_WIDTH bits wide; the count register SHALL be $clog2(MAX_LENGTH+1) bits wide.

Reset
REQ-030 While reset_n is low, src_valid, src_sop, src_eop, src_data, snk_ready and count SHALL be 0, the store SHALL be cleared and the state SHALL be IDLE.
REQ-031 Assertion of reset_n in the middle of a packet SHALL abort the packet immediately, with no partial output.
REQ-032 After reset_n is released, snk_ready SHALL rise on the first rising edge of clock.

Structure
REQ-033 The package sorter_pkg SHALL hold the FSM state type (IDLE, LOAD, OUTPUT) and the default DATA_WIDTH and MAX_LENGTH constants.
REQ-034 One sub-module, sorter_cell, SHALL implement a single store slot: it holds one word, compares it with the incoming word, and either keeps its word, loads the new word, or loads its neighbour's word; sorter_stack SHALL instantiate MAX_LENGTH sorter_cell instances.

Verification
REQ-035 Packet 5,3,9,1,7 (sop on the first word, eop on the last) -> output 1,3,5,7,9 on five consecutive cycles, src_sop with 1 and src_eop with 9, with snk_ready low during output.
REQ-036 Single word 42 with sop and eop both high -> one output cycle, data 42, with src_sop and src_eop both high.
REQ-037 Packet 4,4,2,4 -> output 2,4,4,4, with the output non-decreasing.
REQ-038 A 32-word packet with descending values 31 down to 0 and MAX_LENGTH 30 -> output the 30 sorted values of the first 30 words (2..31), then src_eop.
REQ-039 reset_n driven low after 3 words of a packet -> no output; a following packet 8,6 -> output 6,8.
REQ-040 Randomised packets of length 1 to 30 with random unsigned data -> each output packet is non-decreasing, has the same length as its input, and is a permutation of its input.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared types and default sizing for the insertion-sort packet stack.
package sorter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_MAX_LENGTH = 30;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    OUTPUT
  } state_t;

endpackage

// File: rtl/sorter_cell.sv
// One slot of the sorted store: keeps its word, takes the incoming word,
// or takes its lower neighbour's word when the store shifts up.
import sorter_pkg::*;

module sorter_cell #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit IS_FIRST   = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  restart,
  input  logic                  insert,
  input  logic [DATA_WIDTH-1:0] new_word,
  input  logic [DATA_WIDTH-1:0] prev_word,
  input  logic                  prev_occ,
  input  logic                  prev_gt,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  occ,
  output logic                  gt
);

  // An empty slot behaves as +infinity; strict '>' puts equal keys after
  // the existing ones, which keeps the sort stable.
  assign gt = !occ || (word > new_word);

  // NOTE: the store is part of the reset state, so every slot resets here
  // rather than relying on the occupancy bits alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word <= '0;
      occ  <= 1'b0;
    end else if (restart) begin
      word <= IS_FIRST ? new_word : '0;
      occ  <= IS_FIRST;
    end else if (insert && gt) begin
      if (prev_gt) begin
        word <= prev_word;
        occ  <= prev_occ;
      end else begin
        word <= new_word;
        occ  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sorter_stack.sv
// Packet sorter: loads one word per cycle into an always-sorted store, then
// streams the packet out in ascending unsigned order.
import sorter_pkg::*;

module sorter_stack #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_LENGTH = DEFAULT_MAX_LENGTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  snk_valid,
  input  logic                  snk_sop,
  input  logic                  snk_eop,
  input  logic [DATA_WIDTH-1:0] snk_data,
  output logic                  snk_ready,
  output logic                  src_valid,
  output logic                  src_sop,
  output logic                  src_eop,
  output logic [DATA_WIDTH-1:0] src_data
);

  localparam int CW = $clog2(MAX_LENGTH + 1);

  state_t                state, next_state;
  logic [CW-1:0]         count, rd_idx;
  logic                  accept, restart, insert, last_out;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] word_arr [MAX_LENGTH];
  logic [MAX_LENGTH-1:0] occ_vec, gt_vec;
  logic                  unused_tail;

  assign accept      = snk_valid && snk_ready;
  assign last_out    = (rd_idx == count - CW'(1));
  assign unused_tail = occ_vec[MAX_LENGTH-1] ^ gt_vec[MAX_LENGTH-1];

  for (genvar i = 0; i < MAX_LENGTH; i++) begin : g_cell
    logic [DATA_WIDTH-1:0] prev_word;
    logic                  prev_occ, prev_gt;

    if (i == 0) begin : g_head
      assign prev_word = '0;
      assign prev_occ  = 1'b0;
      assign prev_gt   = 1'b0;
    end else begin : g_link
      assign prev_word = word_arr[i-1];
      assign prev_occ  = occ_vec[i-1];
      assign prev_gt   = gt_vec[i-1];
    end

    sorter_cell #(
      .DATA_WIDTH(DATA_WIDTH),
      .IS_FIRST  (i == 0)
    ) u_cell (
      .clock    (clock),
      .reset_n  (reset_n),
      .restart  (restart),
      .insert   (insert),
      .new_word (snk_data),
      .prev_word(prev_word),
      .prev_occ (prev_occ),
      .prev_gt  (prev_gt),
      .word     (word_arr[i]),
      .occ      (occ_vec[i]),
      .gt       (gt_vec[i])
    );
  end

  // NOTE: every signal written here gets a default first so no latch forms.
  always_comb begin
    next_state = state;
    restart    = 1'b0;
    insert     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && snk_sop) begin
          restart    = 1'b1;
          next_state = snk_eop ? OUTPUT : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (snk_sop) restart = 1'b1;
          else         insert  = (count < CW'(MAX_LENGTH));
          if (snk_eop) next_state = OUTPUT;
        end
      end
      OUTPUT:  if (last_out) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if (rd_idx == CW'(i)) rd_word = word_arr[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      rd_idx <= '0;
    end else begin
      state <= next_state;
      if (restart)     count <= CW'(1);
      else if (insert) count <= count + CW'(1);
      rd_idx <= (state == OUTPUT) ? rd_idx + CW'(1) : '0;
    end
  end

  // snk_ready is registered so it stays low through reset and rises on the
  // first edge after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snk_ready <= 1'b0;
      src_valid <= 1'b0;
      src_sop   <= 1'b0;
      src_eop   <= 1'b0;
      src_data  <= '0;
    end else begin
      snk_ready <= (next_state != OUTPUT);
      src_valid <= (state == OUTPUT);
      src_sop   <= (state == OUTPUT) && (rd_idx == '0);
      src_eop   <= (state == OUTPUT) && last_out;
      if (state == OUTPUT) src_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_sorter_stack.sv
// Scoreboard bench for sorter_stack: stimulus queues expected sorted words,
// a monitor on the falling edge pops and compares every output word.
module tb_sorter_stack;

  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0;
  logic [DW-1:0] snk_data = '0;
  logic          snk_ready, src_valid, src_sop, src_eop;
  logic [DW-1:0] src_data;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } exp_t;

  exp_t exp_q[$];
  int   pkt[$];
  int   exp_vals[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   in_pkt = 1'b0;

  sorter_stack dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .snk_valid(snk_valid),
    .snk_sop  (snk_sop),
    .snk_eop  (snk_eop),
    .snk_data (snk_data),
    .snk_ready(snk_ready),
    .src_valid(src_valid),
    .src_sop  (src_sop),
    .src_eop  (src_eop),
    .src_data (src_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push_expected();
    foreach (exp_vals[i])
      exp_q.push_back('{d: DW'(exp_vals[i]), sop: (i == 0), eop: (i == exp_vals.size() - 1)});
  endtask

  task automatic send_word(input int d, input bit sop, input bit eop);
    int n = 0;
    snk_valid = 1'b1;
    snk_data  = DW'(d);
    snk_sop   = sop;
    snk_eop   = eop;
    while (!snk_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!snk_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL snk_ready_timeout: got 0 required 1");
    end
    @(posedge clock); #1;
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  task automatic run_pkt();
    foreach (pkt[i]) send_word(pkt[i], (i == 0), (i == pkt.size() - 1));
  endtask

  // Monitor: compares every presented word against the scoreboard head.
  always @(negedge clock) begin
    if (reset_n) begin
      if (src_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got data %0d required no output", src_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("src_data", 32'(src_data), 32'(e.d));
          check("src_sop", 32'(src_sop), 32'(e.sop));
          check("src_eop", 32'(src_eop), 32'(e.eop));
        end
        if (!src_eop) check("snk_ready_low_in_output", 32'(snk_ready), 32'd0);
        in_pkt = !src_eop;
      end else if (in_pkt) begin
        n_checks++;
        n_fail++;
        $display("FAIL output_gap: got src_valid 0 required 1");
        in_pkt = 1'b0;
      end
    end
  end

  initial begin
    int n;

    // Reset state and release behaviour.
    repeat (3) @(negedge clock);
    check("rst_snk_ready", 32'(snk_ready), 32'd0);
    check("rst_src_valid", 32'(src_valid), 32'd0);
    check("rst_src_sop", 32'(src_sop), 32'd0);
    check("rst_src_eop", 32'(src_eop), 32'd0);
    check("rst_src_data", 32'(src_data), 32'd0);
    reset_n = 1'b1;
    #1 check("ready_before_first_edge", 32'(snk_ready), 32'd0);
    @(posedge clock); #1;
    check("ready_after_first_edge", 32'(snk_ready), 32'd1);

    // Basic five-word packet.
    pkt = '{5, 3, 9, 1, 7};
    exp_vals = '{1, 3, 5, 7, 9};
    push_expected();
    run_pkt();

    // One-word packet with sop and eop together.
    pkt = '{42};
    exp_vals = '{42};
    push_expected();
    run_pkt();

    // Duplicate keys.
    pkt = '{4, 4, 2, 4};
    exp_vals = '{2, 4, 4, 4};
    push_expected();
    run_pkt();

    // Overflow: 32 descending words, only the first 30 are kept.
    pkt.delete();
    exp_vals.delete();
    for (int v = 31; v >= 0; v--) pkt.push_back(v);
    for (int v = 2; v <= 31; v++) exp_vals.push_back(v);
    push_expected();
    run_pkt();

    // Reset in the middle of a packet aborts it without output.
    send_word(11, 1'b1, 1'b0);
    send_word(12, 1'b0, 1'b0);
    send_word(13, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst_snk_ready", 32'(snk_ready), 32'd0);
    check("midrst_src_valid", 32'(src_valid), 32'd0);
    reset_n = 1'b1;
    pkt = '{8, 6};
    exp_vals = '{6, 8};
    push_expected();
    run_pkt();

    // A second sop inside LOAD restarts the packet.
    exp_vals = '{3, 7};
    push_expected();
    send_word(10, 1'b1, 1'b0);
    send_word(20, 1'b0, 1'b0);
    send_word(7, 1'b1, 1'b0);
    send_word(3, 1'b0, 1'b1);

    // Words without sop in IDLE are ignored.
    send_word(99, 1'b0, 1'b0);
    send_word(77, 1'b0, 1'b1);
    pkt = '{1};
    exp_vals = '{1};
    push_expected();
    run_pkt();

    // Random packets checked against a sorted copy of the input.
    for (int p = 0; p < 4; p++) begin
      int len;
      len = $urandom_range(1, 30);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back($urandom_range(0, 65535));
      exp_vals = pkt;
      exp_vals.sort();
      push_expected();
      run_pkt();
    end

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clock);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (5) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
